// File: rtl/xmint_pkg.sv
// Shared types and helpers for the xmint memory responder.
// Integrity is a 7-bit interleaved parity over the 32-bit response word.
package xmint_pkg;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  // Bit k is the XOR of every data bit whose index is congruent to k mod 7.
  function automatic logic [6:0] intg7(input logic [31:0] data);
    logic [6:0] r;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      r[j % 7] = r[j % 7] ^ data[j];
    end
    return r;
  endfunction

endpackage

// File: rtl/xmint_resp_pipe.sv
// Fixed-latency response delay line: valid plus payload, never stalls.
// Payload of an empty slot is forced to zero so the outputs are clean when idle.
module xmint_resp_pipe
  import xmint_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  in_valid_i,
  input  resp_t in_resp_i,
  output logic  out_valid_o,
  output resp_t out_resp_o,
  output logic  retire_o
);

  logic  [LATENCY-1:0] valid_q, valid_d;
  resp_t [LATENCY-1:0] resp_q, resp_d;

  always_comb begin
    valid_d    = valid_q;
    resp_d     = resp_q;
    valid_d[0] = in_valid_i;
    resp_d[0]  = in_valid_i ? in_resp_i : '0;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      resp_d[i]  = resp_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      resp_q  <= '0;
    end else begin
      valid_q <= valid_d;
      resp_q  <= resp_d;
    end
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign out_resp_o  = resp_q[LATENCY-1];
  assign retire_o    = valid_q[LATENCY-1];

endmodule

// File: rtl/xmint_obi_mem_responder.sv
// Memory-side responder for a req/gnt/rvalid port: word RAM, outstanding limit,
// and fixed-latency in-order responses with integrity bits.
module xmint_obi_mem_responder
  import xmint_pkg::*;
#(
  parameter int          MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  wdata_intg_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o
);

  localparam int              IDX_W = $clog2(MEM_WORDS);
  localparam int              CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0]     SPAN  = 33'(MEM_WORDS) * 33'(WORD_BYTES);
  localparam logic [CNT_W:0]  MAX_C = (CNT_W + 1)'(MAX_OUTSTANDING);

  if ((LATENCY < 1) || (LATENCY > 4)) begin : g_bad_latency
    $error("xmint_obi_mem_responder: LATENCY must be in 1..4");
  end
  if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > LATENCY)) begin : g_bad_outstanding
    $error("xmint_obi_mem_responder: MAX_OUTSTANDING must be in 1..LATENCY");
  end

  logic [31:0]      mem_q [MEM_WORDS];
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   count_eff;
  logic [32:0]      diff;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             transfer;
  logic             retire;
  logic             out_valid;
  resp_t            new_resp;
  resp_t            out_resp;
  logic             unused_intg;

  assign unused_intg = ^wdata_intg_i;

  // A borrow out of the 33-bit subtraction means the address lies below the base.
  assign diff     = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign in_range = !diff[32] && (diff < SPAN);
  assign idx      = diff[IDX_W+1:2];

  // A response leaving this cycle frees its slot for a same-cycle grant.
  assign count_eff = {1'b0, count_q} - (CNT_W + 1)'(retire);
  assign gnt_o     = req_i && (count_eff < MAX_C);
  assign transfer  = req_i && gnt_o;

  always_comb begin
    new_resp = '0;
    if (!in_range) begin
      new_resp.err = 1'b1;
    end else if (!we_i) begin
      new_resp.rdata = mem_q[idx];
    end
  end

  always_comb begin
    count_d = count_q + CNT_W'(transfer) - CNT_W'(retire);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && transfer && we_i && in_range) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be_i[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  xmint_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (transfer),
    .in_resp_i   (new_resp),
    .out_valid_o (out_valid),
    .out_resp_o  (out_resp),
    .retire_o    (retire)
  );

  assign rvalid_o     = out_valid;
  assign rdata_o      = out_resp.rdata;
  assign err_o        = out_resp.err;
  assign rdata_intg_o = intg7(out_resp.rdata);

endmodule
